// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS CPU: sequences IF/ID/EX/MEM/WB,
// drives every datapath enable/select and the branch-condition code.
module mc_ctrl_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic [3:0] PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       ExtOp,
   output logic [1:0] PCSource,
   output logic       IllegalOp,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BR     = 4'd8,
      S_IEX    = 4'd9,
      S_IWB    = 4'd10,
      S_JMP    = 4'd11,
      S_JAL    = 4'd12,
      S_JR     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] FN_JR     = 6'b001000;

   state_t r_state;
   state_t w_next;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IF;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      PCWrite     = 1'b0;
      PCWriteCond = 4'd0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 3'b000;
      ExtOp       = 1'b0;
      PCSource    = 2'b00;
      IllegalOp   = 1'b0;
      State       = r_state;

      case (r_state)
         S_IF: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCWrite = MemReady;
            if (MemReady) w_next = S_ID;
         end
         S_ID: begin
            // Speculatively compute the branch target into ALUOut
            ALUSrcB = 2'b11;
            ExtOp   = 1'b1;
            w_next  = S_IF;
            case (Op)
               OP_RTYPE:  w_next = (Funct == FN_JR) ? S_JR : S_RTEX;
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: w_next = S_BR;
               OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_IEX;
               OP_J:      w_next = S_JMP;
               OP_JAL:    w_next = S_JAL;
               default:   IllegalOp = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ExtOp   = 1'b1;
            w_next  = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (MemReady) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 2'b01;
            w_next   = S_IF;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (MemReady) w_next = S_IF;
         end
         S_RTEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b010;
            w_next  = S_RTWB;
         end
         S_RTWB: begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
            w_next   = S_IF;
         end
         S_BR: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 3'b001;
            PCSource = 2'b01;
            w_next   = S_IF;
            case (Op)
               OP_BEQ:    PCWriteCond = 4'd1;
               OP_REGIMM: PCWriteCond = 4'd2;
               OP_BGTZ:   PCWriteCond = 4'd3;
               OP_BLEZ:   PCWriteCond = 4'd4;
               OP_BNE:    PCWriteCond = 4'd5;
               default:   PCWriteCond = 4'd0;
            endcase
         end
         S_IEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            w_next  = S_IWB;
            case (Op)
               OP_SLTI: begin ALUOp = 3'b101; ExtOp = 1'b1; end
               OP_ANDI: begin ALUOp = 3'b011; ExtOp = 1'b0; end
               OP_ORI:  begin ALUOp = 3'b100; ExtOp = 1'b0; end
               OP_LUI:  begin ALUOp = 3'b110; ExtOp = 1'b0; end
               default: begin ALUOp = 3'b000; ExtOp = 1'b1; end
            endcase
         end
         S_IWB: begin
            RegWrite = 1'b1;
            w_next   = S_IF;
         end
         S_JMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            w_next   = S_IF;
         end
         S_JAL: begin
            // PC already holds PC+4, which becomes the link value
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
            w_next   = S_IF;
         end
         S_JR: begin
            PCWrite  = 1'b1;
            PCSource = 2'b11;
            w_next   = S_IF;
         end
         default: w_next = S_IF;
      endcase

      // Reset abandons the instruction: no enable may leak out this cycle
      if (rst) begin
         PCWrite     = 1'b0;
         PCWriteCond = 4'd0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
         RegDst      = 2'b00;
         MemtoReg    = 2'b00;
         ALUSrcA     = 1'b0;
         ALUSrcB     = 2'b00;
         ALUOp       = 3'b000;
         ExtOp       = 1'b0;
         PCSource    = 2'b00;
         IllegalOp   = 1'b0;
         State       = 4'd0;
      end
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Main control state machine of the multicycle MIPS CPU.
- Sits directly upstream of the branch-condition unit: drives the 4-bit branch-condition code (COND_*) that unit evaluates against ALU zero/sign, plus every datapath enable and mux select.
- Sequences IF/ID/EX/MEM/WB per instruction class and stalls on a memory-ready handshake.

Parameters:
- none (state and condition encodings are fixed below)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  6  instruction opcode, IR[31:26]
- Funct  in  6  instruction function field, IR[5:0]
- MemReady  in  1  memory completes current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  4  branch-condition code: 0 NONE, 1 BEQ, 2 REGIMM (BLTZ/BGEZ), 3 BGTZ, 4 BLEZ, 5 BNE
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- RegWrite  out  1  register-file write
- RegDst  out  2  write register: 00 rt, 01 rd, 10 $31
- MemtoReg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC
- ALUSrcA  out  1  0 PC, 1 A
- ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- ALUOp  out  3  000 add, 001 sub, 010 by Funct, 011 and, 100 or, 101 slt, 110 lui
- ExtOp  out  1  1 sign-extend, 0 zero-extend
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A
- IllegalOp  out  1  one-cycle pulse on undecodable instruction
- State  out  4  current state, for debug

Behaviour:
- States (encoding): IF 0, ID 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BR 8, IEX 9, IWB 10, JMP 11, JAL 12, JR 13. Codes 14-15 are unused and return to IF.
- Every output is 0 unless listed for the current state. Outputs are a function of the current state; Op/Funct/MemReady qualify outputs only where stated.
- Reset: in a cycle with rst=1, all outputs are forced to 0. The next state is IF.
- Reset in any state, including a MemReady wait, abandons the instruction without any write.
- IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00. IRWrite=PCWrite=MemReady. Go to ID if MemReady, else stay in IF.
- ID: ALUSrcA=0, ALUSrcB=11, ALUOp=add, ExtOp=1 (branch target into ALUOut). Decode:
  - R-type (000000): Funct=001000 goes to JR, otherwise RTEX.
  - LW 100011 / SW 101011: MEMADR.
  - BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, REGIMM 000001: BR.
  - ADDI 001000, ADDIU 001001, SLTI 001010, ANDI 001100, ORI 001101, LUI 001111: IEX.
  - J 000010: JMP. JAL 000011: JAL.
  - Any other opcode: IllegalOp=1 this cycle, go to IF.
- Op is sampled only in ID, MEMADR, BR and IEX; IR is stable there.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=add. Go to MEMRD (LW) or MEMWR (SW).
- MEMRD: MemRead=1, IorD=1. Stay until MemReady, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01. Go to IF.
- MEMWR: MemWrite=1, IorD=1. Stay until MemReady, then go to IF.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Go to RTWB.
- RTWB: RegWrite=1, RegDst=01, MemtoReg=00. Go to IF.
- BR: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSource=01, PCWriteCond per Op (BEQ 1, REGIMM 2, BGTZ 3, BLEZ 4, BNE 5). Go to IF.
- PCWriteCond is 0 in every state except BR.
- IEX: ALUSrcA=1, ALUSrcB=10. ALUOp and ExtOp per Op:
  - ADDI/ADDIU: add, ExtOp 1
  - SLTI: slt, ExtOp 1
  - ANDI: and, ExtOp 0
  - ORI: or, ExtOp 0
  - LUI: lui, ExtOp 0
  - Go to IWB.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00. Go to IF.
- JMP: PCWrite=1, PCSource=10. Go to IF.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. PC already holds PC+4 here. Go to IF.
- JR: PCWrite=1, PCSource=11. Go to IF.
- Latency with MemReady held at 1: branch/J/JAL/JR 3 cycles; R-type/I-type/SW 4; LW 5. Each MemReady-low cycle in IF, MEMRD or MEMWR adds one cycle.
- MemReady is ignored outside IF, MEMRD and MEMWR.

Test Plan:
- rst high 2 cycles, then low, MemReady=1 -> all outputs 0 during reset; first cycle after release shows State=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- LW (Op=100011), MemReady low 2 cycles in IF and 3 in MEMRD -> State sequence 0,0,0,1,2,3,3,3,3,4,0; IRWrite only in the third IF cycle; MEMWB shows RegWrite=1, MemtoReg=01.
- BNE (Op=000101) then BLTZ (Op=000001) -> BR shows PCWriteCond=5, then 2; PCSource=01, ALUOp=001; PCWriteCond=0 in all other cycles; 3 cycles each.
- R-type ADD (Funct=100000), then JR (Funct=001000) -> RTEX ALUOp=010, RTWB RegDst=01; JR reaches State 13 with PCWrite=1, PCSource=11.
- ORI then ADDI -> IEX ExtOp=0, ALUOp=100, then ExtOp=1, ALUOp=000; JAL -> State 12 with RegDst=10, MemtoReg=10, PCWrite=1.
- Op=111111 -> IllegalOp=1 for exactly the ID cycle, next State=0. Separately, rst asserted during a MEMWR wait -> MemWrite=0 in the reset cycle; State=0 after.
